// File: rtl/nonlinear_lut_pipe.sv
// Multi-lane back-pressured nonlinear LUT: saturating index slice, shared runtime-writable table,
// overflow counter. Define LUT_INTERP_EN for linear interpolation between entries (adds a third stage).
module nonlinear_lut_pipe #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned IDX_LSB    = 5,
   parameter int unsigned OUT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LANES*DATA_WIDTH-1:0] input_tdata,
   input  logic                        input_tvalid,
   output logic                        input_tready,
   input  logic                        input_tlast,
   output logic [LANES*OUT_WIDTH-1:0]  output_tdata,
   output logic                        output_tvalid,
   input  logic                        output_tready,
   output logic                        output_tlast,
   input  logic                        cfg_wr_en,
   input  logic [ADDR_WIDTH-1:0]       cfg_wr_addr,
   input  logic [OUT_WIDTH-1:0]        cfg_wr_data,
   output logic [31:0]                 ovf_count,
   input  logic                        ovf_clr
);
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned HI_LSB = IDX_LSB + ADDR_WIDTH;
   localparam int unsigned HI_W   = DATA_WIDTH - HI_LSB;
   localparam int unsigned CNT_W  = $clog2(LANES + 1);

   logic [OUT_WIDTH-1:0] table_mem [DEPTH];

   logic [LANES-1:0][ADDR_WIDTH-1:0] lane_idx_c;
   logic [LANES-1:0][IDX_LSB-1:0]    lane_frac_c;
   logic [LANES-1:0]                 lane_sat_c;
   logic [CNT_W-1:0]                 sat_cnt_c;

   logic s1_can_c, s2_can_c, in_fire_c;
   logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [LANES-1:0][ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
   logic [31:0] ovf_q, ovf_d;
   logic [32:0] ovf_sum_c;

`ifdef LUT_INTERP_EN
   localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;
   localparam int unsigned SUM_W = OUT_WIDTH + IDX_LSB + 3;
   localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'({OUT_WIDTH{1'b1}});
   logic s3_can_c, s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
   logic [LANES-1:0][ADDR_WIDTH-1:0] s1_idx1_q, s1_idx1_d;
   logic [LANES-1:0][IDX_LSB-1:0]    s1_frac_q, s1_frac_d, s2_frac_q, s2_frac_d;
   logic [LANES-1:0][OUT_WIDTH-1:0]  s2_e0_q, s2_e0_d, s2_e1_q, s2_e1_d, interp_c;
   logic [LANES-1:0][OUT_WIDTH-1:0]  s3_data_q, s3_data_d;
`else
   logic [LANES-1:0][OUT_WIDTH-1:0]  s2_data_q, s2_data_d;
   logic unused_frac_c;
   assign unused_frac_c = ^lane_frac_c;
`endif

   // Table write port; reads in the same cycle see the old entry
   always_ff @(posedge clk) begin
      if (cfg_wr_en) table_mem[cfg_wr_addr] <= cfg_wr_data;
   end

   // Per-lane index slice with saturation of out-of-range inputs
   always_comb begin
      lane_idx_c  = '0;
      lane_frac_c = '0;
      lane_sat_c  = '0;
      sat_cnt_c   = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sat_c[k]  = |input_tdata[k*DATA_WIDTH + HI_LSB +: HI_W];
         lane_idx_c[k]  = lane_sat_c[k] ? {ADDR_WIDTH{1'b1}}
                                        : input_tdata[k*DATA_WIDTH + IDX_LSB +: ADDR_WIDTH];
         lane_frac_c[k] = lane_sat_c[k] ? '0 : input_tdata[k*DATA_WIDTH +: IDX_LSB];
         sat_cnt_c      = sat_cnt_c + CNT_W'(lane_sat_c[k]);
      end
   end

   // Handshake chain: a stage loads when empty or when its successor loads
   always_comb begin
`ifdef LUT_INTERP_EN
      s3_can_c = !s3_valid_q || output_tready;
      s2_can_c = !s2_valid_q || s3_can_c;
`else
      s2_can_c = !s2_valid_q || output_tready;
`endif
      s1_can_c     = !s1_valid_q || s2_can_c;
      input_tready = !cfg_wr_en && s1_can_c;
      in_fire_c    = input_tvalid && input_tready;
   end

`ifdef LUT_INTERP_EN
   // e0 + (e1-e0)*frac >>> IDX_LSB, clamped to the unsigned output range
   always_comb begin
      logic signed [SUM_W-1:0] diff;
      logic signed [SUM_W-1:0] sum;
      interp_c = '0;
      diff     = '0;
      sum      = '0;
      for (int k = 0; k < LANES; k++) begin
         diff = $signed(SUM_W'(s2_e1_q[k])) - $signed(SUM_W'(s2_e0_q[k]));
         sum  = $signed(SUM_W'(s2_e0_q[k])) + ((diff * $signed(SUM_W'(s2_frac_q[k]))) >>> IDX_LSB);
         if (sum[SUM_W-1])      interp_c[k] = '0;
         else if (sum > OUT_MAX) interp_c[k] = '1;
         else                    interp_c[k] = sum[OUT_WIDTH-1:0];
      end
   end
`endif

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      s1_idx_d   = s1_idx_q;
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
`ifdef LUT_INTERP_EN
      s1_idx1_d  = s1_idx1_q;
      s1_frac_d  = s1_frac_q;
      s2_e0_d    = s2_e0_q;
      s2_e1_d    = s2_e1_q;
      s2_frac_d  = s2_frac_q;
      s3_valid_d = s3_valid_q;
      s3_last_d  = s3_last_q;
      s3_data_d  = s3_data_q;
`else
      s2_data_d  = s2_data_q;
`endif
      ovf_sum_c  = {1'b0, ovf_q} + 33'(sat_cnt_c);
      ovf_d      = ovf_q;

      if (s1_can_c) begin
         s1_valid_d = in_fire_c;
         if (in_fire_c) begin
            s1_last_d = input_tlast;
            s1_idx_d  = lane_idx_c;
`ifdef LUT_INTERP_EN
            s1_frac_d = lane_frac_c;
            for (int k = 0; k < LANES; k++)
               s1_idx1_d[k] = (lane_idx_c[k] == IDX_MAX) ? lane_idx_c[k]
                                                         : lane_idx_c[k] + ADDR_WIDTH'(1);
`endif
         end
      end

      if (s2_can_c) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_last_d = s1_last_q;
`ifdef LUT_INTERP_EN
            s2_frac_d = s1_frac_q;
            for (int k = 0; k < LANES; k++) begin
               s2_e0_d[k] = table_mem[s1_idx_q[k]];
               s2_e1_d[k] = table_mem[s1_idx1_q[k]];
            end
`else
            for (int k = 0; k < LANES; k++) s2_data_d[k] = table_mem[s1_idx_q[k]];
`endif
         end
      end

`ifdef LUT_INTERP_EN
      if (s3_can_c) begin
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            s3_last_d = s2_last_q;
            s3_data_d = interp_c;
         end
      end
`endif

      if (ovf_clr)        ovf_d = '0;
      else if (in_fire_c) ovf_d = ovf_sum_c[32] ? '1 : ovf_sum_c[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_idx_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         ovf_q      <= '0;
`ifdef LUT_INTERP_EN
         s1_idx1_q  <= '0;
         s1_frac_q  <= '0;
         s2_e0_q    <= '0;
         s2_e1_q    <= '0;
         s2_frac_q  <= '0;
         s3_valid_q <= 1'b0;
         s3_last_q  <= 1'b0;
         s3_data_q  <= '0;
`else
         s2_data_q  <= '0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s1_idx_q   <= s1_idx_d;
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
         ovf_q      <= ovf_d;
`ifdef LUT_INTERP_EN
         s1_idx1_q  <= s1_idx1_d;
         s1_frac_q  <= s1_frac_d;
         s2_e0_q    <= s2_e0_d;
         s2_e1_q    <= s2_e1_d;
         s2_frac_q  <= s2_frac_d;
         s3_valid_q <= s3_valid_d;
         s3_last_q  <= s3_last_d;
         s3_data_q  <= s3_data_d;
`else
         s2_data_q  <= s2_data_d;
`endif
      end
   end

`ifdef LUT_INTERP_EN
   assign output_tvalid = s3_valid_q;
   assign output_tlast  = s3_last_q;
   assign output_tdata  = s3_data_q;
`else
   assign output_tvalid = s2_valid_q;
   assign output_tlast  = s2_last_q;
   assign output_tdata  = s2_data_q;
`endif
   assign ovf_count = ovf_q;

endmodule
